// File: rtl/cpu_pkg.sv
// Shared decode definitions: opcodes, controller state encoding and opcode-class helpers.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  function automatic logic [7:0] sext4to8(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction

  // Anything outside the named opcodes is an ALU op that writes W.
  function automatic logic is_alu(input logic [3:0] op);
    case (op)
      OP_NOP, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JMP: return 1'b0;
      default:                                      return 1'b1;
    endcase
  endfunction

  function automatic logic reads_ab(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_JMP);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use and branch-operand hazard detection against the ID/EX slot.
// With DECODE_FWD_EN defined, ALU-producer branch hazards become forward selects instead of stalls.
module hazard_unit
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] a_addr,
  input  logic [3:0] b_addr,
  input  logic       ex_valid,
  input  logic [3:0] ex_opcode,
  input  logic [3:0] ex_w_addr,
`ifdef DECODE_FWD_EN
  output logic       fwd_a,
  output logic       fwd_b,
`endif
  output logic       stall
);

  logic src_match;
  logic load_use;
  logic branch_haz;

  always_comb begin
    src_match  = (ex_w_addr == a_addr) || (ex_w_addr == b_addr);
    load_use   = ex_valid && (ex_opcode == OP_LW) && reads_ab(opcode) && src_match;
    branch_haz = ((opcode == OP_BEQ) || (opcode == OP_BNE)) && ex_valid &&
                 is_alu(ex_opcode) && src_match;
`ifdef DECODE_FWD_EN
    fwd_a = branch_haz && (ex_w_addr == a_addr);
    fwd_b = branch_haz && (ex_w_addr == b_addr);
    stall = load_use;
`else
    stall = load_use || branch_haz;
`endif
  end

endmodule

// File: rtl/id_decode_ctrl.sv
// Decode-stage controller: branch/jump resolution, fetch redirect, hazard stalls and the ID/EX register.
// Optional DECODE_FWD_EN: branch operands are forwarded from ex_fwd_data instead of stalling.
module id_decode_ctrl
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        opcode,
  input  logic [3:0]        A_reg_address,
  input  logic [3:0]        B_reg_address,
  input  logic [3:0]        W_reg_address,
  input  logic [3:0]        Sign,
  input  logic [7:0]        pc_to_im,
  input  logic [7:0]        next_pc_address,
  input  logic [DATA_W-1:0] rd_a_data,
  input  logic [DATA_W-1:0] rd_b_data,
  input  logic [DATA_W-1:0] ex_fwd_data,
  output logic              select_line,
  output logic [7:0]        new_address,
  output logic              pc_select,
  output logic              ex_valid,
  output logic [3:0]        ex_opcode,
  output logic [3:0]        ex_w_addr,
  output logic [3:0]        ex_sign,
  output logic [DATA_W-1:0] ex_a_data,
  output logic [DATA_W-1:0] ex_b_data,
  output logic [7:0]        ex_pc
);

  state_t            state;
  logic [1:0]        flush_cnt;
  logic              hz_stall;
  logic              stall;
  logic              taken;
  logic              cond;
  logic              in_run;
  logic [7:0]        target;
  logic [DATA_W-1:0] a_op;
  logic [DATA_W-1:0] b_op;

`ifdef DECODE_FWD_EN
  logic fwd_a;
  logic fwd_b;
`endif

  hazard_unit u_hazard (
    .opcode    (opcode),
    .a_addr    (A_reg_address),
    .b_addr    (B_reg_address),
    .ex_valid  (ex_valid),
    .ex_opcode (ex_opcode),
    .ex_w_addr (ex_w_addr),
`ifdef DECODE_FWD_EN
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
`endif
    .stall     (hz_stall)
  );

`ifdef DECODE_FWD_EN
  assign a_op = fwd_a ? ex_fwd_data : rd_a_data;
  assign b_op = fwd_b ? ex_fwd_data : rd_b_data;
`else
  logic [DATA_W-1:0] unused_fwd;
  assign unused_fwd = ex_fwd_data;
  assign a_op       = rd_a_data;
  assign b_op       = rd_b_data;
`endif

  always_comb begin
    case (opcode)
      OP_BEQ:  cond = (a_op == b_op);
      OP_BNE:  cond = (a_op != b_op);
      OP_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
    if (opcode == OP_JMP) begin
      target = {A_reg_address, B_reg_address};
    end else begin
      target = next_pc_address + (sext4to8(Sign) << 1);
    end
    in_run = (state == ST_RUN);
    stall  = in_run && hz_stall;
    taken  = in_run && !hz_stall && cond;
    // Redirect outputs are forced to their idle values while reset is held.
    select_line = taken && !reset;
    new_address = (taken && !reset) ? target : 8'h00;
    pc_select   = !stall || reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      flush_cnt <= 2'd0;
    end else if (state == ST_RUN) begin
      if (taken) begin
        state     <= ST_FLUSH;
        flush_cnt <= 2'(FLUSH_CYCLES - 1);
      end else begin
        state     <= ST_RUN;
        flush_cnt <= 2'd0;
      end
    end else if (flush_cnt == 2'd0) begin
      state     <= ST_RUN;
      flush_cnt <= 2'd0;
    end else begin
      state     <= ST_FLUSH;
      flush_cnt <= flush_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_opcode <= OP_NOP;
      ex_w_addr <= 4'h0;
      ex_sign   <= 4'h0;
      ex_a_data <= '0;
      ex_b_data <= '0;
      ex_pc     <= 8'h00;
    end else if (!in_run || stall || taken) begin
      // Flushed instructions, stalls and the redirecting branch itself all become bubbles.
      ex_valid  <= 1'b0;
      ex_opcode <= OP_NOP;
      ex_w_addr <= 4'h0;
      ex_sign   <= 4'h0;
      ex_a_data <= '0;
      ex_b_data <= '0;
      ex_pc     <= 8'h00;
    end else begin
      ex_valid  <= (opcode != OP_NOP);
      ex_opcode <= opcode;
      ex_w_addr <= W_reg_address;
      ex_sign   <= Sign;
      ex_a_data <= a_op;
      ex_b_data <= b_op;
      ex_pc     <= pc_to_im;
    end
  end

endmodule

// File: doc/id_decode_ctrl.md
# id_decode_ctrl

Decode-stage controller at the receiving end of the fetch interface. It consumes the fetch stage's decoded fields and PC values, resolves branches and jumps, and drives the fetch stage's redirect controls `select_line`, `new_address` and `pc_select`. It detects load-use and branch-operand hazards, stalls fetch and squashes wrong-path instructions. Decoded instructions are registered into the ID/EX pipeline register feeding execute.

## Interface
Parameters:
- `FLUSH_CYCLES`, 1: wrong-path instructions squashed after a taken redirect (1–3).
- `DATA_W`, 8: register data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`, `A_reg_address`, `B_reg_address`, `W_reg_address`, `Sign`  in  4 each  fetched instruction fields.
- `pc_to_im`  in  8  PC of the presented instruction.
- `next_pc_address`  in  8  `pc_to_im + 2`.
- `rd_a_data`, `rd_b_data`  in  DATA_W  register-file read data for A/B addresses.
- `ex_fwd_data`  in  DATA_W  EX-stage ALU result; used only with `DECODE_FWD_EN`.
- `select_line`  out  1  1 = fetch takes `new_address`.
- `new_address`  out  8  redirect target.
- `pc_select`  out  1  1 = PC loads, 0 = PC holds.
- `ex_valid`  out  1  ID/EX slot holds a real instruction.
- `ex_opcode`, `ex_w_addr`, `ex_sign`  out  4 each  registered fields.
- `ex_a_data`, `ex_b_data`  out  DATA_W  registered operands.
- `ex_pc`  out  8  registered `pc_to_im`.

## Operation
- Opcodes: NOP=0x0, LW=0x8, SW=0x9, BEQ=0xA, BNE=0xB, JMP=0xC. All other opcodes are ALU ops that write W.
- Sources: every opcode except NOP and JMP reads A and B.
- Writers: ALU ops and LW.
- FSM states: RUN, FLUSH.
  - RUN → FLUSH on a taken redirect.
  - FLUSH counts `FLUSH_CYCLES` cycles, then returns to RUN.
- Load-use hazard (RUN): `ex_valid`, `ex_opcode`=LW, and `ex_w_addr` equals a source address of the current instruction. Response for that cycle: `pc_select`=0, bubble inserted into ID/EX, `select_line`=0.
- Branch-operand hazard: current BEQ/BNE, `ex_valid`, EX opcode is an ALU op, and `ex_w_addr` matches A or B. Response: stall exactly like a load-use hazard.
- Branch target: `next_pc_address + (sext(Sign) << 1)`, computed mod 256.
- JMP target: `{A_reg_address, B_reg_address}`.
- Taken redirect: BEQ with A==B, BNE with A!=B, or JMP, all without a hazard. Outputs for that cycle: `select_line`=1, `new_address`=target, `pc_select`=1. The branch/jump itself enters ID/EX as a bubble.
- FLUSH: the presented instruction is ignored. It is not hazard-checked and cannot redirect; it enters ID/EX as a bubble. `pc_select`=1, `select_line`=0.
- Normal issue: `ex_*` ← current fields/data, `ex_valid`=1 (NOP gives `ex_valid`=0).
- Priority: stall > redirect > issue.

## Timing
- `select_line`, `new_address` and `pc_select` are combinational from inputs, the FSM state and the ID/EX register, so the PC acts on the same clock edge.
- ID/EX outputs have one-cycle latency.
- A stall lasts exactly 1 cycle, because the inserted bubble clears the hazard.
- A taken branch costs 1 + `FLUSH_CYCLES` slots.
- Reset values: `ex_valid`=0, `ex_opcode`=NOP, all other `ex_*`=0, FSM=RUN. Combinational outputs settle to `select_line`=0, `new_address`=0, `pc_select`=1.
- Reset asserted during FLUSH aborts the flush; the FSM returns to RUN.
- Target wraps at 8 bits: 0xFE + 2 gives 0x00.

## Configuration
- `DECODE_FWD_EN` defined: a branch-operand hazard against an EX ALU op does not stall. The matching operand is taken from `ex_fwd_data` for both the compare and the `ex_*_data` capture. Load-use hazards still stall.
- `DECODE_FWD_EN` undefined: `ex_fwd_data` is ignored, and any EX-writer dependency of a BEQ/BNE stalls 1 cycle.

## Structure
- Package `cpu_pkg` holds the opcode localparams, the FSM state enum, and a `sext4to8` function.
- One sub-module, `hazard_unit`: combinational load-use and branch-operand detection, with the forward-select output compiled under `DECODE_FWD_EN`.

## Test plan
- LW r3 followed by ALU reading r3 → one cycle with `pc_select`=0, then `ex_valid`=0 for one cycle, then the ALU op issues with correct data.
- BEQ at PC 0x10, Sign=0xE, equal operands → `select_line`=1, `new_address`=0x0E; the next instruction is squashed (`ex_valid`=0).
- BNE with equal operands → not taken, `select_line`=0, no flush, sequential issue continues.
- JMP A=0x4, B=0x2 → `new_address`=0x42. With `FLUSH_CYCLES`=2, two bubbles follow.
- ALU writes r5, then BEQ r5,r5: without the macro, a 1-cycle stall; with the macro, no stall and the branch is taken using `ex_fwd_data`.
- Reset asserted during FLUSH → all `ex_*` zero immediately, FSM=RUN, and the first instruction after reset deassertion issues normally.
